// File: rtl/shift_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// shift_sequencer_pkg
//   Shared definitions for the shift sequencer:
//   - state_t      : sequencer FSM states (IDLE, SHIFT, RESP)
//   - PASS_MAX_DEF : default largest count handled by one shifter pass
//   - *_FN         : shifter opcode encodings
//   - pass_count() : count for the next pass, min(rem, pass_max)
//   - is_shift_op(): true for opcodes that shift bits out (carry-producing)
// ---------------------------------------------------------------------------
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int PASS_MAX_DEF = 7;

  localparam logic [3:0] SHL_FN = 4'h8;
  localparam logic [3:0] SHR_FN = 4'h9;
  localparam logic [3:0] ROL_FN = 4'hA;
  localparam logic [3:0] ROR_FN = 4'hB;

  // Clamp the remaining count to what one shifter pass can do.
  function automatic logic [2:0] pass_count(input logic [7:0] rem,
                                            input logic [2:0] pass_max);
    logic [2:0] res;
    if (rem > {5'd0, pass_max}) begin
      res = pass_max;
    end else begin
      res = rem[2:0];
    end
    return res;
  endfunction

  // Only plain shifts move a bit out into the carry; rotates and
  // pass-through leave the carry at zero.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == SHL_FN) || (op == SHR_FN);
  endfunction

endpackage

// File: rtl/shift_sequencer_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-requester round-robin grant with a single priority flop.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset (prio -> 0)
//     valid0/1     : requester valids
//     update       : strobe when a response completes
//     last_id      : id of the requester just served; prio becomes ~last_id
//     grant        : index of the granted requester
//     grant_valid  : at least one requester is valid
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic update,
  input  logic last_id,
  output logic grant,
  output logic grant_valid
);

  logic prio;

  // Priority flop: favour the requester that was not served last.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (update) begin
      prio <= ~last_id;
    end else begin
      prio <= prio;
    end
  end

  // Grant the favoured requester if it is valid, otherwise the other one.
  always_comb begin
    grant_valid = valid0 | valid1;
    if (prio ? valid1 : valid0) begin
      grant = prio;
    end else begin
      grant = ~prio;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Shares one external 8-bit/3-bit-count shifter between two requesters.
//   A request with count up to 2^CNT_W-1 is split into passes of at most
//   PASS_MAX; each pass result is fed back as the next pass operand. The
//   final result and C/Z flags are returned on a valid/ready channel.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     req{0,1}_valid/ready     : request handshake (ready is combinational)
//     req{0,1}_data/opcode/count : request payload
//     sh_data/sh_opcode/sh_count : drive to the shifter (0 outside SHIFT)
//     sh_out/sh_C/sh_Z         : shifter result and flags
//     rsp_valid/rsp_ready      : response handshake
//     rsp_id/result/C/Z        : response payload
// ---------------------------------------------------------------------------
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int PASS_MAX = PASS_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_data,
  input  logic [3:0]       req0_opcode,
  input  logic [CNT_W-1:0] req0_count,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_data,
  input  logic [3:0]       req1_opcode,
  input  logic [CNT_W-1:0] req1_count,
  output logic [7:0]       sh_data,
  output logic [3:0]       sh_opcode,
  output logic [2:0]       sh_count,
  input  logic [7:0]       sh_out,
  input  logic             sh_C,
  input  logic             sh_Z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_result,
  output logic             rsp_C,
  output logic             rsp_Z
);

  localparam logic [2:0] PMAX = 3'(PASS_MAX);

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic             id;
  logic             carry;

  logic             grant;
  logic             grant_valid;
  logic             accept;
  logic [7:0]       sel_data;
  logic [3:0]       sel_opcode;
  logic [CNT_W-1:0] sel_count;
  logic [CNT_W-1:0] rem_next;
  logic             carry_next;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .update      ((state == RESP) && rsp_ready),
    .last_id     (rsp_id),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Ready/accept decode and selection of the granted request payload.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && (state == IDLE) && grant_valid) begin
      req0_ready = (grant == 1'b0) && req0_valid;
      req1_ready = (grant == 1'b1) && req1_valid;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    accept = req0_ready | req1_ready;
    if (grant) begin
      sel_data   = req1_data;
      sel_opcode = req1_opcode;
      sel_count  = req1_count;
    end else begin
      sel_data   = req0_data;
      sel_opcode = req0_opcode;
      sel_count  = req0_count;
    end
  end

  // Per-pass bookkeeping. sh_count holds the current pass amount; a zero
  // pass (count 0 request) must not disturb the carry.
  always_comb begin
    rem_next = rem - CNT_W'(sh_count);
    if (sh_count != 3'd0) begin
      carry_next = is_shift_op(sh_opcode) ? sh_C : 1'b0;
    end else begin
      carry_next = carry;
    end
  end

  // Sequencer FSM. The sh_* registers double as the working operand and
  // latched opcode, so they are cleared whenever the FSM leaves SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      id         <= 1'b0;
      carry      <= 1'b0;
      sh_data    <= 8'd0;
      sh_opcode  <= 4'd0;
      sh_count   <= 3'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 8'd0;
      rsp_C      <= 1'b0;
      rsp_Z      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sh_data   <= sel_data;
            sh_opcode <= sel_opcode;
            sh_count  <= pass_count(8'(sel_count), PMAX);
            rem       <= sel_count;
            id        <= grant;
            carry     <= 1'b0;
            state     <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          rem   <= rem_next;
          carry <= carry_next;
          if (rem_next == '0) begin
            rsp_result <= sh_out;
            rsp_C      <= carry_next;
            rsp_Z      <= sh_Z;
            rsp_id     <= id;
            rsp_valid  <= 1'b1;
            sh_data    <= 8'd0;
            sh_opcode  <= 4'd0;
            sh_count   <= 3'd0;
            state      <= RESP;
          end else begin
            sh_data  <= sh_out;
            sh_count <= pass_count(8'(rem_next), PMAX);
            state    <= SHIFT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          sh_data   <= 8'd0;
          sh_opcode <= 4'd0;
          sh_count  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that shares one combinational `shifter` instance (8-bit data, 3-bit count) between two requesters.
- Accepts shift requests with counts up to 15 and splits them into passes of at most 7.
- Feeds each pass result back into the shifter and returns the final result with C/Z flags through a valid/ready response channel.
- Sits between the ALU issue logic and the shared shifter datapath.

Parameters:
- CNT_W, 4, width of the request shift count; count range is 0..2^CNT_W-1.
- PASS_MAX, 7, maximum count per shifter pass; must not exceed 7.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_data  input  8  operand.
- req0_opcode  input  4  SHL_FN/SHR_FN/ROL_FN/ROR_FN; any other value passes data through.
- req0_count  input  CNT_W  total shift amount.
- req1_valid, req1_ready, req1_data, req1_opcode, req1_count: same as req0, for requester 1.
- sh_data  output  8  operand driven to the shifter.
- sh_opcode  output  4  opcode driven to the shifter.
- sh_count  output  3  pass count driven to the shifter.
- sh_out  input  8  shifter result.
- sh_C  input  1  shifter carry.
- sh_Z  input  1  shifter zero flag.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  index of the requester that issued the request.
- rsp_result  output  8  final shifted value.
- rsp_C  output  1  final carry.
- rsp_Z  output  1  final zero flag.

Behaviour:
- FSM states: IDLE, SHIFT, RESP.
- Reset state: IDLE; prio=0 (req0 favoured); rsp_valid=0; rsp_id=0; rsp_result=0; rsp_C=0; rsp_Z=0; sh_* driven 0. Both readys are 0 while rst=1.
- IDLE, grant: grant = prio if that requester is valid, else the other valid one.
- IDLE, ready: reqX_ready=1 combinationally only when in IDLE, grant==X and reqX_valid=1. At most one ready is high per cycle.
- IDLE, accept: on acceptance, latch work_data, op, rem=count and id; clear carry; go to SHIFT.
- SHIFT, drive: each cycle sh_data=work_data, sh_opcode=op, sh_count=pass where pass=min(rem, PASS_MAX).
- SHIFT, update: at the clock edge, work_data<=sh_out and rem<=rem-pass. If pass>0, carry<=sh_C. If rem-pass==0, latch rsp_result=sh_out, rsp_C=carry/sh_C, rsp_Z=sh_Z, rsp_id=id, set rsp_valid=1 and go to RESP.
- Count 0: exactly one pass with sh_count=0; result=data, C=0, Z=(data==0).
- Pass count and latency: number of passes is max(1, ceil(count/PASS_MAX)). With acceptance in cycle T, rsp_valid rises at T+1+passes.
- Carry: the carry of the final nonzero pass, i.e. the last bit shifted out. Rotates and pass-through opcodes always give C=0.
- RESP: all rsp_* outputs hold stable while rsp_valid=1 and rsp_ready=0. No request is accepted in this state.
- RESP handshake: on rsp_valid&rsp_ready, clear rsp_valid, set prio=~rsp_id (round-robin) and go to IDLE.
- Throughput: at most one request per 1+passes+1 cycles.
- Input stability: request inputs need only be stable in the accept cycle; later changes are ignored.
- Opcode and count latching: opcode and count are latched, never re-sampled mid-operation.
- Reset mid-operation: on rst=1 in any state, the next state is IDLE with all reset values. The in-flight request is dropped, with no response.
- sh_* outputs outside SHIFT: driven 0 in IDLE and RESP.

Decomposition:
- Shared package: state enum (IDLE, SHIFT, RESP), PASS_MAX default constant, opcode constants (SHL_FN, SHR_FN, ROL_FN, ROR_FN from the existing defines).
- One natural sub-module: rr_arbiter2, the two-requester round-robin grant with a priority flop. It takes an update strobe and the last-served id.
- The shifter is instantiated outside; the sequencer only drives its ports.

Test Plan:
- Reset, then req0: data=8'hB5, SHL_FN, count=3, accepted at T -> sh_count=3 at T+1; rsp_valid at T+2 with result=8'hA8, C=1, Z=0, id=0.
- req1: data=8'h81, ROR_FN, count=9 -> passes sh_count=7 then 2; rsp_valid at T+3 with result=8'hC0, C=0, Z=0, id=1.
- req0: data=8'h80, SHR_FN, count=8 -> passes 7 then 1; result=8'h00, C=1, Z=1. Also count=0 with data=8'h00 -> single pass, result=8'h00, C=0, Z=1.
- Both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1. Each rsp_id matches the granting requester; never two readys in one cycle.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req0_ready=req1_ready=0. On release: one handshake, then a new accept possible the following cycle.
- rst pulsed during the second pass of a count=14 request -> next cycle IDLE, rsp_valid=0, prio=0, sh_count=0. No response is issued for the dropped request.
